// File: rtl/mem_stage_dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem_ctrl_if
// Bundle between the EX/MEM pipeline register (master side) and the MEM-stage
// data-memory responder (slave side).
//   mem_read_in / mem_write_in : load / store request strobes
//   address_in                 : byte address (ALU result)
//   write_data_in              : store data
//   read_data_out              : registered load data
//   data_valid_out             : one-cycle completion pulse
//   stall_out                  : freeze EX/MEM and earlier stages
//   misaligned_out             : misaligned-request trap flag
// -----------------------------------------------------------------------------
interface mem_stage_dmem_ctrl_if;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [31:0] address_in;
   logic [31:0] write_data_in;
   logic [31:0] read_data_out;
   logic        data_valid_out;
   logic        stall_out;
   logic        misaligned_out;

   modport master (
      output mem_read_in, mem_write_in, address_in, write_data_in,
      input  read_data_out, data_valid_out, stall_out, misaligned_out
   );

   modport slave (
      input  mem_read_in, mem_write_in, address_in, write_data_in,
      output read_data_out, data_valid_out, stall_out, misaligned_out
   );
endinterface

// File: rtl/mem_stage_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem_ctrl
// MEM-stage data-memory responder. Latches the EX/MEM request in IDLE, waits
// LATENCY BUSY cycles while holding stall_out, performs the array access on
// the last BUSY edge and presents a one-cycle data_valid_out in DONE.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (control and read_data_out only;
//          the data array itself is never reset)
//   bus  : mem_stage_dmem_ctrl_if.slave (request in, load data/status out)
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : IDLE requests with address_in[1:0] != 0 are rejected with a
//               combinational misaligned_out pulse and no state change
//   undefined : misaligned_out tied low, byte offset ignored
//
// Parameters:
//   ADDR_W  : word-index width, array depth 2**ADDR_W x 32 bits
//   LATENCY : BUSY cycles per access, 1..15
// -----------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_stage_dmem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;
   logic                lat_write;
   logic [ADDR_W-1:0]   lat_idx;
   logic [31:0]         lat_data;
   logic [31:0]         mem [0:(1<<ADDR_W)-1];

   logic                request;
   logic                misaligned;
   logic                accept;
   logic                access_now;

   // Address bits above the word index wrap away; the byte offset matters only
   // when the misalignment trap is built in.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{bus.address_in[31:ADDR_W+2], bus.address_in[1:0]};

   // ---------------- request decode / next state ----------------
   always_comb begin
      request    = bus.mem_read_in | bus.mem_write_in;
`ifdef MISALIGN_TRAP_EN
      misaligned = (state == IDLE) && request && (bus.address_in[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      accept     = (state == IDLE) && request && !misaligned;
      access_now = (state == BUSY) && (cnt == 4'd0);

      state_nxt          = state;
      bus.stall_out      = 1'b0;
      bus.data_valid_out = 1'b0;
      bus.misaligned_out = misaligned;

      case (state)
         IDLE: begin
            if (accept) begin
               bus.stall_out = 1'b1;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            bus.stall_out = 1'b1;
            if (cnt == 4'd0) state_nxt = DONE;
         end
         DONE: begin
            // EX/MEM still holds the serviced instruction; ignore its strobes.
            bus.data_valid_out = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- control / latched request / load data ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= 4'd0;
         lat_write         <= 1'b0;
         lat_idx           <= '0;
         lat_data          <= 32'd0;
         bus.read_data_out <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Read+write together is serviced as a write.
            lat_write <= bus.mem_write_in;
            lat_idx   <= bus.address_in[ADDR_W+1:2];
            lat_data  <= bus.write_data_in;
            cnt       <= 4'(LATENCY - 1);
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access_now && !lat_write) begin
            bus.read_data_out <= mem[lat_idx];
         end
      end
   end

   // ---------------- array write (not reset; blocked by reset) ----------------
   always_ff @(posedge clk) begin
      if (!rst && access_now && lat_write) begin
         mem[lat_idx] <= lat_data;
      end
   end

endmodule
